seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg_scan_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display-side bundle of the seven-segment scan driver.
// Shadow-load request lines plus registered anode/cathode pins.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dots;
  logic                    load;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [7:0]              seg_out;

  modport master (
    output digits, dots, load, lz_en,
    input  an_out, seg_out
  );

  modport slave (
    input  digits, dots, load, lz_en,
    output an_out, seg_out
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Define SEGSCAN_HEX_EN to decode codes 10..15 as A,b,C,d,E,F.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic      clk,
  input logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    run_q, run_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dot_q, sh_dot_d;
  logic                    sh_lz_q, sh_lz_d;

  logic                    tick;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_code;
  logic [7:0]              pat;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
`ifdef SEGSCAN_HEX_EN
      4'd10:   s = 7'h08;
      4'd11:   s = 7'h03;
      4'd12:   s = 7'h46;
      4'd13:   s = 7'h21;
      4'd14:   s = 7'h06;
      4'd15:   s = 7'h0E;
`endif
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Leading-zero mask: blank a digit when it and all digits above are zero.
  always_comb begin
    logic zr;
    zr = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zr = zr & (sh_dig_q[4*i +: 4] == 4'd0);
      lz_blank[i] = sh_lz_q & (i != 0) & zr;
    end
  end

  // Pattern for the digit about to be selected, taken from the shadow copy.
  always_comb begin
    cur_code = sh_dig_q[4*int'(idx_d) +: 4];
    pat = {~sh_dot_q[idx_d],
           lz_blank[idx_d] ? 7'h7F : decode(cur_code)};
  end

  // Prescaler, digit index, blank/drive phase and shadow loading.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    run_d = run_q | tick;
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = '1;
      seg_d = pat;
    end else if (run_q) begin
      an_d        = '1;
      an_d[idx_q] = 1'b0;
    end
    sh_dig_d = bus.load ? bus.digits : sh_dig_q;
    sh_dot_d = bus.load ? bus.dots   : sh_dot_q;
    sh_lz_d  = bus.load ? bus.lz_en  : sh_lz_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= IDX_MAX;
      run_q    <= 1'b0;
      an_q     <= '1;
      seg_q    <= 8'hFF;
      sh_dig_q <= '0;
      sh_dot_q <= '0;
      sh_lz_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      sh_dig_q <= sh_dig_d;
      sh_dot_q <= sh_dot_d;
      sh_lz_q  <= sh_lz_d;
    end
  end

  assign bus.an_out  = an_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver, NUM_DIGITS=4, REFRESH_DIV=4.
// Hex expectations follow SEGSCAN_HEX_EN.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of a BLANK cycle; returns at the next one.
  task automatic slot(input logic [3:0] ea, input logic [7:0] es,
                      input string tag);
    chk({tag, "/blank_an"}, {4'h0, bus.an_out}, 8'h0F);
    chk({tag, "/blank_seg"}, bus.seg_out, es);
    cyc(1);
    bus.load = 1'b0;
    chk({tag, "/an"}, {4'h0, bus.an_out}, {4'h0, ea});
    chk({tag, "/seg"}, bus.seg_out, es);
    cyc(2);
    chk({tag, "/an_end"}, {4'h0, bus.an_out}, {4'h0, ea});
    chk({tag, "/seg_end"}, bus.seg_out, es);
    cyc(1);
  endtask

  initial begin
    logic [7:0] h0, h1, h2, h3;
`ifdef SEGSCAN_HEX_EN
    h0 = 8'h8E; h1 = 8'h86; h2 = 8'h83; h3 = 8'h88;
`else
    h0 = 8'hFF; h1 = 8'hFF; h2 = 8'hFF; h3 = 8'hFF;
`endif
    rst_n      = 1'b0;
    bus.digits = '0;
    bus.dots   = '0;
    bus.load   = 1'b0;
    bus.lz_en  = 1'b0;
    cyc(3);
    chk("rst_an", {4'h0, bus.an_out}, 8'h0F);
    chk("rst_seg", bus.seg_out, 8'hFF);
    rst_n = 1'b1;
    cyc(3);
    chk("pre_tick_an", {4'h0, bus.an_out}, 8'h0F);
    cyc(1);
    slot(4'hE, 8'hC0, "first_d0");

    bus.digits = 16'h1234;
    bus.dots   = 4'b0100;
    bus.lz_en  = 1'b0;
    bus.load   = 1'b1;
    slot(4'hD, 8'hC0, "scan_old_d1");
    slot(4'hB, 8'h24, "scan_d2");
    slot(4'h7, 8'hF9, "scan_d3");
    slot(4'hE, 8'h99, "scan_d0");
    slot(4'hD, 8'hB0, "scan_d1");

    bus.digits = 16'h0050;
    bus.dots   = 4'b0000;
    bus.lz_en  = 1'b1;
    bus.load   = 1'b1;
    slot(4'hB, 8'h24, "lz_old_d2");
    slot(4'h7, 8'hFF, "lz_d3");
    slot(4'hE, 8'hC0, "lz_d0");
    slot(4'hD, 8'h92, "lz_d1");
    slot(4'hB, 8'hFF, "lz_d2");

    bus.lz_en = 1'b0;
    bus.load  = 1'b1;
    slot(4'h7, 8'hFF, "nolz_old_d3");
    slot(4'hE, 8'hC0, "nolz_d0");
    slot(4'hD, 8'h92, "nolz_d1");
    slot(4'hB, 8'hC0, "nolz_d2");
    slot(4'h7, 8'hC0, "nolz_d3");

    chk("col_blank_seg", bus.seg_out, 8'hC0);
    cyc(1);
    chk("col_an", {4'h0, bus.an_out}, 8'h0E);
    cyc(2);
    bus.digits = 16'h9999;
    bus.load   = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    slot(4'hD, 8'h92, "col_old_d1");
    slot(4'hB, 8'h90, "col_new_d2");

    bus.digits = 16'hABEF;
    bus.load   = 1'b1;
    slot(4'h7, 8'h90, "hex_old_d3");
    slot(4'hE, h0, "hex_d0");
    slot(4'hD, h1, "hex_d1");
    slot(4'hB, h2, "hex_d2");
    slot(4'h7, h3, "hex_d3");

    cyc(2);
    chk("mid_drive_an", {4'h0, bus.an_out}, 8'h0E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {4'h0, bus.an_out}, 8'h0F);
    chk("mid_rst_seg", bus.seg_out, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("rerun_pre_an", {4'h0, bus.an_out}, 8'h0F);
    cyc(1);
    slot(4'hE, 8'hC0, "rerun_d0");
    slot(4'hD, 8'hC0, "rerun_d1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
